// File: rtl/cache_tag_unit.sv
// Set-associative tag store: registered lookup, line fill, victim select, invalidate walk.
// Ports: lk_* lookup req, rsp_* result, fill_* tag write, inv_start/inv_busy walk control.
module cache_tag_unit #(
  parameter int TAG_W = 16,
  parameter int IDX_W = 8,
  parameter int WAYS  = 2,
  localparam int WW   = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lk_valid,
  output logic             lk_ready,
  input  logic [TAG_W-1:0] lk_tag,
  input  logic [IDX_W-1:0] lk_idx,
  output logic             rsp_valid,
  output logic             rsp_hit,
  output logic [WW-1:0]    rsp_way,
  output logic [WW-1:0]    rsp_victim,
  input  logic             fill_valid,
  input  logic [IDX_W-1:0] fill_idx,
  input  logic [WW-1:0]    fill_way,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic             inv_start,
  output logic             inv_busy
);

  localparam int SETS = 1 << IDX_W;

  typedef enum logic {READY, INV} state_t;

  state_t state_q, state_d;

  logic [IDX_W-1:0] cnt_q;
  logic [WAYS-1:0]  valid_q [SETS];
  logic [WW-1:0]    rr_q    [SETS];
  logic [TAG_W-1:0] tag_q   [SETS][WAYS];

  logic          acc;
  logic          fill_en;
  logic [WW-1:0] fway;
  logic [WW-1:0] rr_nxt;
  logic          hit;
  logic [WW-1:0] hway;
  logic          ifound;
  logic [WW-1:0] vic;

  // Gate with rst_n so ready reads low while reset is held.
  assign lk_ready = rst_n && (state_q == READY);
  assign inv_busy = (state_q == INV);
  assign acc      = lk_valid && lk_ready;
  assign fill_en  = fill_valid && lk_ready;
  assign fway     = (WAYS > 1) ? fill_way : '0;
  assign rr_nxt   = (WAYS == 1 || fill_way == WW'(WAYS - 1))
                    ? '0 : fill_way + 1'b1;

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      state_q == READY: if (inv_start) state_d = INV;
      state_q == INV:   if (&cnt_q) state_d = READY;
      default:          state_d = READY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= READY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == INV) cnt_q <= cnt_q + 1'b1;
      else                cnt_q <= '0;
    end
  end

  // Lowest matching way wins; victim prefers lowest invalid way.
  always_comb begin
    hit    = 1'b0;
    hway   = '0;
    ifound = 1'b0;
    vic    = rr_q[lk_idx];
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[lk_idx][w] &&
          tag_q[lk_idx][w] == lk_tag) begin
        hit  = 1'b1;
        hway = WW'(w);
      end
      if (!ifound && !valid_q[lk_idx][w]) begin
        ifound = 1'b1;
        vic    = WW'(w);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_hit    <= 1'b0;
      rsp_way    <= '0;
      rsp_victim <= '0;
    end else begin
      rsp_valid  <= acc;
      rsp_hit    <= acc && hit;
      rsp_way    <= (acc && hit) ? hway : '0;
      rsp_victim <= (acc && !hit) ? vic : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else if (state_q == INV) begin
      valid_q[cnt_q] <= '0;
      rr_q[cnt_q]    <= '0;
    end else if (fill_valid) begin
      valid_q[fill_idx][fway] <= 1'b1;
      rr_q[fill_idx]          <= rr_nxt;
    end
  end

  // Tag array carries no reset; valid bits qualify it.
  always_ff @(posedge clk) begin
    if (fill_en) tag_q[fill_idx][fway] <= fill_tag;
  end

endmodule

// File: tb/tb_cache_tag_unit.sv
// Bench for cache_tag_unit: directed scenarios plus random traffic
// checked against an array-based reference model.
module tb_cache_tag_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lk_valid = 1'b0;
  logic        lk_ready;
  logic [15:0] lk_tag = '0;
  logic [7:0]  lk_idx = '0;
  logic        rsp_valid;
  logic        rsp_hit;
  logic [0:0]  rsp_way;
  logic [0:0]  rsp_victim;
  logic        fill_valid = 1'b0;
  logic [7:0]  fill_idx = '0;
  logic [0:0]  fill_way = '0;
  logic [15:0] fill_tag = '0;
  logic        inv_start = 1'b0;
  logic        inv_busy;

  int checks = 0;
  int failures = 0;

  logic [15:0] m_tag [256][2];
  bit          m_val [256][2];
  bit          m_rr  [256];

  always #5 clk = ~clk;

  cache_tag_unit #(.TAG_W(16), .IDX_W(8), .WAYS(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .lk_valid(lk_valid), .lk_ready(lk_ready),
    .lk_tag(lk_tag), .lk_idx(lk_idx),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit),
    .rsp_way(rsp_way), .rsp_victim(rsp_victim),
    .fill_valid(fill_valid), .fill_idx(fill_idx),
    .fill_way(fill_way), .fill_tag(fill_tag),
    .inv_start(inv_start), .inv_busy(inv_busy)
  );

  task automatic m_clear();
    for (int s = 0; s < 256; s++) begin
      m_val[s][0] = 0;
      m_val[s][1] = 0;
      m_rr[s] = 0;
    end
  endtask

  // Expected {valid,hit,way,victim} for a lookup against model state.
  function automatic logic [3:0] m_rsp(input logic [15:0] t,
                                       input logic [7:0] i);
    for (int w = 0; w < 2; w++)
      if (m_val[i][w] && m_tag[i][w] == t)
        return {1'b1, 1'b1, 1'(w), 1'b0};
    for (int w = 0; w < 2; w++)
      if (!m_val[i][w]) return {1'b1, 1'b0, 1'b0, 1'(w)};
    return {1'b1, 1'b0, 1'b0, m_rr[i]};
  endfunction

  // One clock: drive, predict, advance model, land at posedge+1.
  task automatic step(input bit lv, input logic [15:0] t,
                      input logic [7:0] i, input bit fv,
                      input logic [7:0] fi, input bit fw,
                      input logic [15:0] ft, output logic [3:0] exp_r);
    lk_valid = lv; lk_tag = t; lk_idx = i;
    fill_valid = fv; fill_idx = fi; fill_way = fw; fill_tag = ft;
    exp_r = (lv && lk_ready) ? m_rsp(t, i) : 4'b0;
    @(posedge clk);
    if (fv && lk_ready) begin
      m_tag[fi][fw] = ft;
      m_val[fi][fw] = 1;
      m_rr[fi] = ~fw;
    end
    #1;
    lk_valid = 0; fill_valid = 0;
  endtask

  function automatic logic [3:0] got();
    return {rsp_valid, rsp_hit, rsp_way, rsp_victim};
  endfunction

  task automatic test_reset();
    m_clear();
    #1;
    checks++;
    if ({lk_ready, rsp_valid, inv_busy} !== 3'b000) begin
      failures++;
      $display("FAIL reset_outs got=%b exp=000",
               {lk_ready, rsp_valid, inv_busy});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    checks++;
    if ({lk_ready, rsp_valid, inv_busy} !== 3'b100) begin
      failures++;
      $display("FAIL release_outs got=%b exp=100",
               {lk_ready, rsp_valid, inv_busy});
    end
  endtask

  task automatic test_directed();
    logic [3:0] e;
    step(1, 16'h1234, 8'h05, 0, 0, 0, 0, e);
    checks++;
    if (got() !== 4'b1000 || e !== 4'b1000) begin
      failures++;
      $display("FAIL first_miss got=%b exp=1000", got());
    end
    step(0, 0, 0, 0, 0, 0, 0, e);
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL pulse_end got=%b exp=0", rsp_valid);
    end
    step(0, 0, 0, 1, 8'h05, 0, 16'h1234, e);
    step(1, 16'h1234, 8'h05, 0, 0, 0, 0, e);
    checks++;
    if (got() !== 4'b1100) begin
      failures++;
      $display("FAIL hit_w0 got=%b exp=1100", got());
    end
    step(1, 16'hABCD, 8'h05, 0, 0, 0, 0, e);
    checks++;
    if (got() !== 4'b1001) begin
      failures++;
      $display("FAIL miss_vic1 got=%b exp=1001", got());
    end
    step(0, 0, 0, 1, 8'h05, 1, 16'hABCD, e);
    step(1, 16'h5555, 8'h05, 0, 0, 0, 0, e);
    checks++;
    if (got() !== 4'b1000) begin
      failures++;
      $display("FAIL rr_wrap got=%b exp=1000", got());
    end
    step(1, 16'h1234, 8'h05, 0, 0, 0, 0, e);
    checks++;
    if (got() !== 4'b1100) begin
      failures++;
      $display("FAIL b2b_first got=%b exp=1100", got());
    end
    step(1, 16'hABCD, 8'h05, 0, 0, 0, 0, e);
    checks++;
    if (got() !== 4'b1110) begin
      failures++;
      $display("FAIL b2b_second got=%b exp=1110", got());
    end
    step(1, 16'h00FF, 8'h09, 1, 8'h09, 0, 16'h00FF, e);
    checks++;
    if (got() !== 4'b1000) begin
      failures++;
      $display("FAIL rbw_pre got=%b exp=1000", got());
    end
    step(1, 16'h00FF, 8'h09, 0, 0, 0, 0, e);
    checks++;
    if (got() !== 4'b1100) begin
      failures++;
      $display("FAIL rbw_post got=%b exp=1100", got());
    end
  endtask

  task automatic test_random();
    logic [3:0] e;
    logic [15:0] tags [4];
    int bad = 0;
    tags[0] = 16'h1111; tags[1] = 16'h2222;
    tags[2] = 16'h3333; tags[3] = 16'h4444;
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 3) != 0),
           tags[$urandom_range(0, 3)], 8'($urandom_range(16, 19)),
           1'($urandom_range(0, 2) == 0),
           8'($urandom_range(16, 19)), 1'($urandom_range(0, 1)),
           tags[$urandom_range(0, 3)], e);
      checks++;
      if (got() !== e) begin
        failures++;
        if (bad < 5)
          $display("FAIL rand_rsp n=%0d got=%b exp=%b", n, got(), e);
        bad++;
      end
    end
  endtask

  task automatic test_inv();
    logic [3:0] e;
    int busy = 0;
    inv_start = 1;
    step(1, 16'h1234, 8'h05, 1, 8'h07, 0, 16'h4444, e);
    inv_start = 0;
    checks++;
    if (got() !== e || e !== 4'b1100) begin
      failures++;
      $display("FAIL inv_same_cycle got=%b exp=%b", got(), e);
    end
    while (inv_busy === 1'b1 && busy < 400) begin
      busy++;
      if (lk_ready !== 1'b0) begin
        checks++;
        failures++;
        $display("FAIL walk_ready got=%b exp=0", lk_ready);
      end
      if (busy == 100) begin
        fill_valid = 1; fill_idx = 8'h05;
        fill_way = 0; fill_tag = 16'hBEEF;
      end
      @(posedge clk); #1;
      fill_valid = 0;
    end
    m_clear();
    checks++;
    if (busy !== 256) begin
      failures++;
      $display("FAIL walk_len got=%0d exp=256", busy);
    end
    step(1, 16'h1234, 8'h05, 0, 0, 0, 0, e);
    checks++;
    if (got() !== 4'b1000) begin
      failures++;
      $display("FAIL post_inv got=%b exp=1000", got());
    end
    step(1, 16'hBEEF, 8'h05, 0, 0, 0, 0, e);
    checks++;
    if (got() !== 4'b1000) begin
      failures++;
      $display("FAIL walk_fill got=%b exp=1000", got());
    end
    step(1, 16'h4444, 8'h07, 0, 0, 0, 0, e);
    checks++;
    if (got() !== 4'b1000) begin
      failures++;
      $display("FAIL inv_cycle_fill got=%b exp=1000", got());
    end
  endtask

  task automatic test_reset_midwalk();
    logic [3:0] e;
    step(0, 0, 0, 1, 8'd200, 1, 16'h7777, e);
    step(0, 0, 0, 1, 8'd5, 0, 16'h1234, e);
    inv_start = 1;
    @(posedge clk); #1;
    inv_start = 0;
    repeat (100) @(posedge clk);
    #1;
    lk_valid = 1; lk_tag = 16'h7777; lk_idx = 8'd200;
    rst_n = 0;
    #1;
    checks++;
    if ({inv_busy, lk_ready, rsp_valid} !== 3'b000) begin
      failures++;
      $display("FAIL midwalk_rst got=%b exp=000",
               {inv_busy, lk_ready, rsp_valid});
    end
    lk_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    m_clear();
    @(posedge clk); #1;
    checks++;
    if ({lk_ready, inv_busy} !== 2'b10) begin
      failures++;
      $display("FAIL rst_release got=%b exp=10", {lk_ready, inv_busy});
    end
    step(1, 16'h7777, 8'd200, 0, 0, 0, 0, e);
    checks++;
    if (got() !== 4'b1000) begin
      failures++;
      $display("FAIL rst_cleared got=%b exp=1000", got());
    end
    step(1, 16'h1234, 8'd5, 0, 0, 0, 0, e);
    checks++;
    if (got() !== 4'b1000) begin
      failures++;
      $display("FAIL rst_cleared5 got=%b exp=1000", got());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_inv();
    test_reset_midwalk();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
